// File: rtl/accumulator_datapath_if.sv
// Control-word and status bundle between the accumulator control unit (master) and the datapath (slave).
// The datapath returns the ACC, the ALU debug result and the Z/N flags.
interface accumulator_datapath_if #(
  parameter int DATA_WIDTH    = 16,
  parameter int OPERAND_WIDTH = 11
);
  logic [OPERAND_WIDTH-1:0] operand_in;
  logic [DATA_WIDTH-1:0]    ext_in;
  logic [1:0]               sel_A_in;
  logic                     sel_B_in;
  logic                     alu_op_in;
  logic                     data_memory_wr_in;
  logic                     acc_wr_in;
  logic                     status_wr_in;
  logic                     acc_reset_in;
  logic                     status_reset_in;
  logic [DATA_WIDTH-1:0]    acc_out;
  logic [DATA_WIDTH-1:0]    alu_result_out;
  logic                     status_Z_out;
  logic                     status_N_out;

  modport master (
    output operand_in, ext_in, sel_A_in, sel_B_in, alu_op_in,
           data_memory_wr_in, acc_wr_in, status_wr_in, acc_reset_in, status_reset_in,
    input  acc_out, alu_result_out, status_Z_out, status_N_out
  );

  modport slave (
    input  operand_in, ext_in, sel_A_in, sel_B_in, alu_op_in,
           data_memory_wr_in, acc_wr_in, status_wr_in, acc_reset_in, status_reset_in,
    output acc_out, alu_result_out, status_Z_out, status_N_out
  );
endinterface

// File: rtl/accumulator_datapath.sv
// Accumulator execution stage: ACC, Z/N flags, add/sub ALU, source muxes and data memory.
// Single-cycle: each control word takes effect at the next rising edge; no backpressure.
module accumulator_datapath #(
  parameter int DATA_WIDTH      = 16,
  parameter int OPERAND_WIDTH   = 11,
  parameter int DATA_ADDR_WIDTH = 11
) (
  input  logic                  clock_in,
  input  logic                  reset_in,
  accumulator_datapath_if.slave dp
);

  logic [DATA_WIDTH-1:0]      mem [2**DATA_ADDR_WIDTH];
  logic [DATA_WIDTH-1:0]      acc;
  logic [DATA_WIDTH-1:0]      sext;
  logic [DATA_WIDTH-1:0]      mem_rd;
  logic [DATA_WIDTH-1:0]      alu_b;
  logic [DATA_WIDTH-1:0]      alu_result;
  logic [DATA_WIDTH-1:0]      sel_a_val;
  logic [DATA_ADDR_WIDTH-1:0] addr;
  logic                       status_z;
  logic                       status_n;

  assign sext   = {{(DATA_WIDTH-OPERAND_WIDTH){dp.operand_in[OPERAND_WIDTH-1]}}, dp.operand_in};
  assign addr   = dp.operand_in[DATA_ADDR_WIDTH-1:0];
  assign mem_rd = mem[addr];
  assign alu_b  = dp.sel_B_in ? sext : mem_rd;

  // Wrap-around is silent; no carry or overflow is kept.
  assign alu_result = dp.alu_op_in ? (acc - alu_b) : (acc + alu_b);

  always_comb begin
    sel_a_val = mem_rd;
    case (dp.sel_A_in)
      2'b00:   sel_a_val = mem_rd;
      2'b01:   sel_a_val = sext;
      2'b10:   sel_a_val = alu_result;
      default: sel_a_val = dp.ext_in;
    endcase
  end

  always_ff @(posedge clock_in or negedge reset_in) begin
    if (!reset_in) begin
      acc      <= '0;
      status_z <= 1'b0;
      status_n <= 1'b0;
    end else begin
      if (dp.acc_reset_in) begin
        acc <= '0;
      end else if (dp.acc_wr_in) begin
        acc <= sel_a_val;
      end
      // Flags follow the mux value even when ACC is being cleared in the same cycle.
      if (dp.status_reset_in) begin
        status_z <= 1'b0;
        status_n <= 1'b0;
      end else if (dp.status_wr_in) begin
        status_z <= (sel_a_val == '0);
        status_n <= sel_a_val[DATA_WIDTH-1];
      end
    end
  end

  // Memory is not reset; a store captures the pre-edge ACC, so the read port sees the old word.
  always_ff @(posedge clock_in) begin
    if (dp.data_memory_wr_in) begin
      mem[addr] <= acc;
    end
  end

  assign dp.acc_out        = acc;
  assign dp.alu_result_out = alu_result;
  assign dp.status_Z_out   = status_z;
  assign dp.status_N_out   = status_n;

endmodule

// File: tb/tb_accumulator_datapath.sv
// Bench for accumulator_datapath: directed scenarios with fixed expected values,
// then randomized control words scored against an arithmetic reference model.
module tb_accumulator_datapath;

  logic clk;
  logic rst_n;

  accumulator_datapath_if #(.DATA_WIDTH(16), .OPERAND_WIDTH(11)) dp ();

  accumulator_datapath #(
    .DATA_WIDTH(16), .OPERAND_WIDTH(11), .DATA_ADDR_WIDTH(11)
  ) dut (
    .clock_in (clk),
    .reset_in (rst_n),
    .dp       (dp)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  // Reference state
  logic [15:0] m_acc;
  logic        m_z;
  logic        m_n;
  logic [15:0] mem_m [2048];
  bit          mem_v [2048];

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic logic [15:0] sext16(input logic [10:0] op);
    int s;
    s = int'(op);
    if (s >= 1024) s = s - 2048;
    return 16'(s);
  endfunction

  // One control word: drive at the falling edge, check ALU, clock it, check registers.
  task automatic cycle(input logic [10:0] op, input logic [15:0] ext, input logic [1:0] sa,
                       input logic sb, input logic aop, input logic mwr, input logic awr,
                       input logic swr, input logic ares, input logic sres);
    logic [15:0] bval, alu, v;
    bit          b_ok, v_ok;
    int          sum;
    dp.operand_in = op;        dp.ext_in = ext;         dp.sel_A_in = sa;
    dp.sel_B_in = sb;          dp.alu_op_in = aop;      dp.data_memory_wr_in = mwr;
    dp.acc_wr_in = awr;        dp.status_wr_in = swr;   dp.acc_reset_in = ares;
    dp.status_reset_in = sres;
    b_ok = sb || mem_v[op];
    bval = sb ? sext16(op) : mem_m[op];
    if (aop) sum = (int'(m_acc) - int'(bval) + 65536) % 65536;
    else     sum = (int'(m_acc) + int'(bval)) % 65536;
    alu = 16'(sum);
    case (sa)
      2'd0:    begin v = mem_m[op];  v_ok = mem_v[op]; end
      2'd1:    begin v = sext16(op); v_ok = 1;         end
      2'd2:    begin v = alu;        v_ok = b_ok;      end
      default: begin v = ext;        v_ok = 1;         end
    endcase
    #1;
    if (b_ok) check_eq("alu_result", 32'(dp.alu_result_out), 32'(alu));
    @(posedge clk);
    if (mwr) begin
      mem_m[op] = m_acc;
      mem_v[op] = 1;
    end
    if (ares)          m_acc = 16'h0;
    else if (awr)      m_acc = v_ok ? v : 16'hxxxx;
    if (sres)          begin m_z = 0; m_n = 0; end
    else if (swr)      begin m_z = (v == 16'h0); m_n = (v >= 16'h8000); end
    @(negedge clk);
    check_eq("acc", 32'(dp.acc_out), 32'(m_acc));
    check_eq("status_z", 32'(dp.status_Z_out), 32'(m_z));
    check_eq("status_n", 32'(dp.status_N_out), 32'(m_n));
  endtask

  task automatic ldi(input logic [10:0] op);
    cycle(op, 16'h0, 2'd1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0);
  endtask

  task automatic sto(input logic [10:0] op);
    cycle(op, 16'h0, 2'd1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
  endtask

  initial begin
    logic [10:0] op;
    logic [1:0]  sa;
    logic        sb, mwr;
    m_acc = 16'h0; m_z = 0; m_n = 0;
    rst_n = 1'b0;
    dp.operand_in = '0; dp.ext_in = '0; dp.sel_A_in = '0; dp.sel_B_in = 1'b1;
    dp.alu_op_in = 0; dp.data_memory_wr_in = 0; dp.acc_wr_in = 0; dp.status_wr_in = 0;
    dp.acc_reset_in = 0; dp.status_reset_in = 0;
    repeat (2) @(negedge clk);
    check_eq("reset_acc", 32'(dp.acc_out), 32'h0);
    check_eq("reset_z", 32'(dp.status_Z_out), 32'h0);
    check_eq("reset_n", 32'(dp.status_N_out), 32'h0);
    rst_n = 1'b1;

    // Asynchronous reset mid-cycle with ACC = 1234 and Z = 1
    cycle(11'h0, 16'h1234, 2'd3, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
    check_eq("ext_load", 32'(dp.acc_out), 32'h1234);
    cycle(11'h0, 16'h0, 2'd1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
    check_eq("z_set", 32'(dp.status_Z_out), 32'h1);
    #2 rst_n = 1'b0;
    #1;
    check_eq("async_rst_acc", 32'(dp.acc_out), 32'h0);
    check_eq("async_rst_z", 32'(dp.status_Z_out), 32'h0);
    check_eq("async_rst_n", 32'(dp.status_N_out), 32'h0);
    m_acc = 16'h0; m_z = 0; m_n = 0;
    @(negedge clk);
    rst_n = 1'b1;

    // LDI 5, ADDI -1, SUBI 4, SUBI 1
    ldi(11'h005);
    check_eq("ldi5", 32'(dp.acc_out), 32'h5);
    cycle(11'h7FF, 16'h0, 2'd2, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0);
    check_eq("addi_m1", 32'(dp.acc_out), 32'h4);
    cycle(11'h004, 16'h0, 2'd2, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0);
    check_eq("subi4", 32'(dp.acc_out), 32'h0);
    check_eq("subi4_z", 32'(dp.status_Z_out), 32'h1);
    cycle(11'h001, 16'h0, 2'd2, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0);
    check_eq("subi1", 32'(dp.acc_out), 32'hFFFF);
    check_eq("subi1_n", 32'(dp.status_N_out), 32'h1);

    // STO/LD round trip, then read-during-write on the same address
    ldi(11'h0AB);
    sto(11'd13);
    ldi(11'h000);
    cycle(11'd13, 16'h0, 2'd0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0);
    check_eq("ld13", 32'(dp.acc_out), 32'h00AB);
    ldi(11'h055);
    cycle(11'd13, 16'h0, 2'd0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
    check_eq("rdw_old", 32'(dp.acc_out), 32'h00AB);
    cycle(11'd13, 16'h0, 2'd0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
    check_eq("rdw_new", 32'(dp.acc_out), 32'h0055);

    // Memory operand with wrap-around
    ldi(11'h001);
    sto(11'd2);
    ldi(11'h7FF);
    cycle(11'd2, 16'h0, 2'd2, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0);
    check_eq("add_wrap", 32'(dp.acc_out), 32'h0);
    check_eq("add_wrap_z", 32'(dp.status_Z_out), 32'h1);
    cycle(11'd2, 16'h0, 2'd2, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0);
    check_eq("sub_wrap", 32'(dp.acc_out), 32'hFFFF);
    check_eq("sub_wrap_n", 32'(dp.status_N_out), 32'h1);

    // Priorities
    cycle(11'h007, 16'h0, 2'd1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0);
    check_eq("acc_reset_prio", 32'(dp.acc_out), 32'h0);
    cycle(11'h400, 16'h0, 2'd1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1);
    check_eq("status_reset_prio_z", 32'(dp.status_Z_out), 32'h0);
    check_eq("status_reset_prio_n", 32'(dp.status_N_out), 32'h0);
    cycle(11'h7FF, 16'h0, 2'd1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0);
    check_eq("flags_follow_v_acc", 32'(dp.acc_out), 32'h0);
    check_eq("flags_follow_v_n", 32'(dp.status_N_out), 32'h1);
    cycle(11'h000, 16'h8000, 2'd3, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0);
    check_eq("ext_8000", 32'(dp.acc_out), 32'h8000);
    check_eq("ext_8000_n", 32'(dp.status_N_out), 32'h1);

    // Seed low memory, then random control words
    for (int i = 0; i < 16; i++) begin
      ldi(11'($urandom));
      sto(11'(i));
    end
    for (int i = 0; i < 400; i++) begin
      sa  = 2'($urandom_range(0, 3));
      sb  = 1'($urandom);
      mwr = ($urandom_range(0, 3) == 0);
      op  = (sa == 2'd0 || !sb || mwr) ? 11'($urandom_range(0, 15)) : 11'($urandom);
      cycle(op, 16'($urandom), sa, sb, 1'($urandom), mwr, 1'($urandom), 1'($urandom),
            ($urandom_range(0, 7) == 0), ($urandom_range(0, 7) == 0));
    end

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/accumulator_datapath.md
Name: accumulator_datapath

Overview:
- Downstream execution stage of the accumulator processor; consumes the operand and control strobes produced by the control unit each cycle.
- Holds the accumulator (ACC), the Z/N status flags, the add/sub ALU, the source muxes and the data memory.
- Returns status_Z/status_N to the control unit so it can evaluate branches.
- Single-cycle execution: every control word presented in a cycle takes effect at the next rising clock edge.

Parameters:
DATA_WIDTH, 16, width of ACC, ALU, memory words and ext_in
OPERAND_WIDTH, 11, width of operand_in from the control unit
DATA_ADDR_WIDTH, 11, data memory address width; depth = 2**DATA_ADDR_WIDTH words

Ports:
clock_in  input  1  system clock, rising-edge active
reset_in  input  1  asynchronous, active-low reset
operand_in  input  OPERAND_WIDTH  immediate value or data memory address
ext_in  input  DATA_WIDTH  external input word
sel_A_in  input  2  ACC source select: 00 mem, 01 sext(operand), 10 ALU result, 11 ext_in
sel_B_in  input  1  ALU B source: 0 mem, 1 sext(operand)
alu_op_in  input  1  0 = ACC+B, 1 = ACC-B
data_memory_wr_in  input  1  write ACC to mem[operand] at clock edge
acc_wr_in  input  1  load ACC from sel_A mux
status_wr_in  input  1  update Z/N from sel_A mux value
acc_reset_in  input  1  synchronous clear of ACC
status_reset_in  input  1  synchronous clear of Z and N
acc_out  output  DATA_WIDTH  current ACC value
alu_result_out  output  DATA_WIDTH  combinational ALU result (debug/bench)
status_Z_out  output  1  zero flag register
status_N_out  output  1  negative flag register

Behaviour:
- Reset (reset_in = 0, asynchronous): ACC = 0, Z = 0, N = 0 immediately. Memory contents are not reset (undefined until written). Reset is released synchronously to the first following rising edge. Reset asserted mid-write aborts that write's effect on ACC/status; memory write in the same edge is not guaranteed.
- Operand handling: sext = operand_in sign-extended from OPERAND_WIDTH to DATA_WIDTH. Memory address = operand_in[DATA_ADDR_WIDTH-1:0].
- Memory: read is combinational (mem_rd = mem[addr]); write is synchronous. On a rising edge with data_memory_wr_in = 1, mem[addr] <= ACC value before the edge.
- Read-during-write to the same address in one cycle: the read returns the old word; the new word is visible from the next cycle.
- ALU: B = sel_B_in ? sext : mem_rd. Result = ACC ± B modulo 2**DATA_WIDTH; no carry or overflow flag; wrap-around is silent.
- sel_A mux value V feeds both ACC and status.
- ACC update priority at each edge: acc_reset_in (ACC = 0) > acc_wr_in (ACC = V) > hold.
- Status update priority: status_reset_in (Z = 0, N = 0) > status_wr_in (Z = (V == 0), N = V[DATA_WIDTH-1]) > hold. Flags reflect V, not the post-reset ACC, when acc_reset_in and status_wr_in coincide.
- Store-then-accumulate in one cycle (data_memory_wr_in and acc_wr_in both 1): memory receives the old ACC.
- All outputs are registers except alu_result_out. Flags change only on a clock edge or on reset.

Test Plan:
- Reset: assert reset_in = 0 with ACC = 16'h1234 and Z = 1 -> acc_out = 0, Z = 0, N = 0 before the next edge.
- LDI then ADDI: operand 11'h005, sel_A = 01, acc_wr = 1, status_wr = 1 -> ACC = 5, Z = 0, N = 0. Next cycle operand 11'h7FF (-1), sel_B = 1, alu_op = 0, sel_A = 10 -> ACC = 4.
- SUBI to zero then negative: ACC = 4, SUBI 4 -> ACC = 0, Z = 1. Then SUBI 1 -> ACC = 16'hFFFF, Z = 0, N = 1.
- STO/LD round-trip: ACC = 16'h00AB, STO addr 13 -> next cycle LD addr 13 (sel_A = 00) -> ACC = 16'h00AB. Read-during-write: STO and LD addr 13 in the same cycle -> ACC gets the old mem[13].
- ADD/SUB from memory with wrap: mem[2] = 16'h0001, ACC = 16'hFFFF, ADD (sel_B = 0) -> ACC = 0, Z = 1. SUB (alu_op = 1) -> ACC = 16'hFFFF, N = 1.
- Priority: acc_reset = 1 and acc_wr = 1 with V = 7 -> ACC = 0. status_reset = 1 and status_wr = 1 -> Z = 0, N = 0. ext_in = 16'h8000, sel_A = 11, acc_wr = 1, status_wr = 1 -> ACC = 16'h8000, N = 1.
